mux_sel_arbiter: RTL and testbench
==================================

# mux_sel_arbiter

Four-channel round-robin arbiter that sits directly upstream of the 4:1 data multiplexer. It drives the multiplexer's 2-bit select and a one-hot grant back to the requesters. It holds a grant until the owner releases it, drops its request, or (optionally) exceeds a hold limit. This makes the combinational mux a fair, time-shared channel selector.

## Interface
- `HOLD_MAX`, default 16: maximum cycles a grant is held. Used only when the timeout feature is compiled in. Legal range 2..255.
- `clk` in 1: single clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req` in 4: per-channel request, level-sensitive.
- `rel` in 1: current owner releases the grant. Sampled only while `valid`=1.
- `sel` out 2: select to the 4:1 mux; index of the granted channel.
- `gnt` out 4: one-hot grant; all-zero when idle.
- `valid` out 1: a grant is active. Equals the OR of `gnt`.
- `timeout` out 1: one-cycle pulse when a grant is forcibly revoked.

## Operation
- Reset values:
  - `sel`=0, `gnt`=0, `valid`=0, `timeout`=0.
  - Round-robin pointer `last`=3, so the first search starts at channel 0.
  - Hold counter = 0.
- Pick function: the first set bit of `req` scanning `last+1`, `last+2`, … modulo 4 (wrap 3→0). Result is a 2-bit index plus a found flag.
- FSM has two states:
  - IDLE: if any `req` bit is set, grant the picked channel, set `last` to that index, and go to GRANT. Otherwise stay in IDLE.
  - GRANT: end the grant on any of these, sampled at the edge:
    - `rel`=1;
    - `req[sel]`=0;
    - timeout (feature on).
  - On grant end:
    - If the pick over the current `req` finds a channel, grant it on the same edge and stay in GRANT. There is no bubble.
    - Otherwise go to IDLE.
    - A releasing channel that still requests can be re-granted only when no other channel requests.
- In IDLE, `sel` retains the last granted index and `gnt`=0. Consumers must qualify mux output with `valid`.
- `rel` while IDLE is ignored.
- The `gnt` one-hot encoding always matches `sel` when `valid`=1.

## Timing
- Grant latency: `req` set before edge k means `gnt`/`valid`/`sel` update after edge k (1 cycle).
- Release latency: `rel` high at edge k means the new grant, or `valid`=0, appears after edge k.
- Back-to-back handover costs zero idle cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `rst` assertion forces reset values immediately, mid-grant included. The first grant after deassertion follows the pick from `last`=3.

## Configuration
- Macro `MUX_SEL_ARB_TIMEOUT_EN`.
- Defined:
  - A hold counter clears on every new grant and increments each cycle in GRANT.
  - When it reaches `HOLD_MAX-1` without a release, that edge ends the grant as a forced release.
  - `timeout` is high for exactly the following cycle.
  - A simultaneous `rel` on the same edge counts as a normal release, with `timeout`=0.
- Undefined: there is no counter, `timeout` is tied to 0, and grants are held indefinitely.

## Structure
- Shared package `mux_sel_arb_pkg`:
  - constants `N_CH`=4 and `SEL_W`=2;
  - state enum typedef `arb_state_t` {IDLE, GRANT}.
- One sub-module `rr_pick`: combinational rotate-and-find-first over `req` from `last+1`. Outputs are the index and a found flag.
- The top level holds the FSM, the `last` register, the output registers and the conditional hold counter.

## Test plan
- Reset: `rst`=1 with `req`=4'b1111 gives `gnt`=0, `valid`=0, `sel`=0. Deassert `rst`: after the next edge, `gnt`=4'b0001 and `sel`=0.
- Rotation: `req`=4'b1111 held, `rel` pulsed for one cycle each grant. `sel` sequence is 0,1,2,3,0 with `valid` continuously high.
- Sparse requests: `req`=4'b1010 from reset, `rel` pulsed each grant. `sel` sequence is 1,3,1,3.
- Request drop: owner channel 2 drops `req` with no `rel` while `req[0]`=1. Next edge gives `gnt`=4'b0001. If no other request is pending, `valid`=0 instead.
- Timeout (macro on, `HOLD_MAX`=4): `req`=4'b0011, no `rel`. `gnt`=4'b0001 for 4 cycles, then `gnt`=4'b0010 with `timeout`=1 for one cycle. With the macro off, `gnt` stays 4'b0001.
- Reset mid-grant: assert `rst` asynchronously while `gnt`=4'b0100. Outputs clear before the next edge. After release with `req`=4'b0100, the grant reappears on channel 2 after one edge.

Source files
------------

// File: rtl/mux_sel_arb_pkg.sv
// Shared constants and FSM state type for the four-channel round-robin mux select arbiter.
package mux_sel_arb_pkg;
    localparam int N_CH  = 4;
    localparam int SEL_W = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;
endpackage

// File: rtl/mux_sel_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
import mux_sel_arb_pkg::*;

interface mux_sel_arbiter_if;
    logic [N_CH-1:0]  req;
    logic             rel;
    logic [SEL_W-1:0] sel;
    logic [N_CH-1:0]  gnt;
    logic             valid;
    logic             timeout;

    // Level handshake: req is held high while a channel wants the mux; the owner is
    // the channel whose gnt bit is set while valid=1, and ownership ends on the edge
    // where rel=1, its req is low, or the hold limit forces it off.
    modport master (output req, output rel,
                    input sel, input gnt, input valid, input timeout);
    modport slave  (input req, input rel,
                    output sel, output gnt, output valid, output timeout);
endinterface

// File: rtl/mux_sel_arbiter_rr_pick.sv
// Combinational round-robin pick: first set request scanning from last+1 upward, wrapping 3->0.
import mux_sel_arb_pkg::*;

module rr_pick (
    input  logic [N_CH-1:0]  req,
    input  logic [SEL_W-1:0] last,
    output logic [SEL_W-1:0] idx,
    output logic             found
);
    logic [SEL_W-1:0] ch;

    always_comb begin
        idx   = '0;
        found = 1'b0;
        ch    = '0;
        // i = N_CH wraps back to last itself, so the previous owner is considered last
        for (int i = 1; i <= N_CH; i++) begin
            ch = last + SEL_W'(i);
            if (!found && req[ch]) begin
                idx   = ch;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving a 4:1 mux select and one-hot grant; MUX_SEL_ARB_TIMEOUT_EN
// adds a hold-limit counter that forcibly revokes a grant after HOLD_MAX cycles.
import mux_sel_arb_pkg::*;

module mux_sel_arbiter #(
    parameter int HOLD_MAX = 16
) (
    input  logic               clk,
    input  logic               rst,
    mux_sel_arbiter_if.slave   bus,
    output arb_state_t         state
);
    arb_state_t       state_q, state_n;
    logic [SEL_W-1:0] last_q, last_n;
    logic [SEL_W-1:0] sel_q, sel_n;
    logic [N_CH-1:0]  gnt_q, gnt_n;
    logic             valid_q, valid_n;
    logic             timeout_q, timeout_n;
    logic [SEL_W-1:0] pick_idx;
    logic             pick_found;
    logic             hold_hit;
    logic             new_grant;
    logic             end_grant;

    rr_pick u_pick (
        .req   (bus.req),
        .last  (last_q),
        .idx   (pick_idx),
        .found (pick_found)
    );

`ifdef MUX_SEL_ARB_TIMEOUT_EN
    logic [7:0] hold_cnt_q, hold_cnt_n;

    assign hold_hit = (state_q == GRANT) && (hold_cnt_q == 8'(HOLD_MAX - 1));

    always_comb begin
        hold_cnt_n = hold_cnt_q;
        if (new_grant)
            hold_cnt_n = '0;
        else if (state_q == GRANT)
            hold_cnt_n = hold_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) hold_cnt_q <= '0;
        else     hold_cnt_q <= hold_cnt_n;
    end
`else
    logic [7:0] unused_hold;
    assign unused_hold = 8'(HOLD_MAX - 1);
    assign hold_hit    = 1'b0;
`endif

    always_comb begin
        state_n   = state_q;
        last_n    = last_q;
        sel_n     = sel_q;
        gnt_n     = gnt_q;
        valid_n   = valid_q;
        timeout_n = 1'b0;
        new_grant = 1'b0;
        end_grant = 1'b0;
        case (state_q)
            IDLE: begin
                new_grant = pick_found;
            end
            GRANT: begin
                end_grant = bus.rel || !bus.req[sel_q] || hold_hit;
                // Only a pure hold-limit expiry counts as a forced revoke
                timeout_n = hold_hit && !bus.rel && bus.req[sel_q];
                new_grant = end_grant && pick_found;
                if (end_grant && !pick_found) begin
                    state_n = IDLE;
                    gnt_n   = '0;
                    valid_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
        if (new_grant) begin
            state_n = GRANT;
            last_n  = pick_idx;
            sel_n   = pick_idx;
            gnt_n   = N_CH'(1) << pick_idx;
            valid_n = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            last_q    <= SEL_W'(N_CH - 1);
            sel_q     <= '0;
            gnt_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            last_q    <= last_n;
            sel_q     <= sel_n;
            gnt_q     <= gnt_n;
            valid_q   <= valid_n;
            timeout_q <= timeout_n;
        end
    end

    assign bus.sel     = sel_q;
    assign bus.gnt     = gnt_q;
    assign bus.valid   = valid_q;
    assign bus.timeout = timeout_q;
    assign state       = state_q;
endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed-vector bench for mux_sel_arbiter with hand-computed expectations (HOLD_MAX=4).
import mux_sel_arb_pkg::*;

module tb_mux_sel_arbiter;
    logic       clk;
    logic       rst;
    arb_state_t state;
    int         checks;
    int         errors;

    mux_sel_arbiter_if bus ();

    mux_sel_arbiter #(.HOLD_MAX(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .state (state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL sim_timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.req = '0;
        bus.rel = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic expect_grant(input string tag, input logic [1:0] s);
        check({tag, "_sel"}, 32'(bus.sel), 32'(s));
        check({tag, "_gnt"}, 32'(bus.gnt), 32'(4'b0001 << s));
        check({tag, "_valid"}, 32'(bus.valid), 32'd1);
    endtask

    logic [1:0] rot_exp [4];
    logic [1:0] sparse_exp [3];

    initial begin
        checks  = 0;
        errors  = 0;
        rot_exp = '{2'd1, 2'd2, 2'd3, 2'd0};
        sparse_exp = '{2'd3, 2'd1, 2'd3};

        // reset with all channels requesting
        rst     = 1'b1;
        bus.req = 4'b1111;
        bus.rel = 1'b0;
        tick();
        tick();
        check("rst_gnt", 32'(bus.gnt), 32'h0);
        check("rst_valid", 32'(bus.valid), 32'h0);
        check("rst_sel", 32'(bus.sel), 32'h0);
        check("rst_timeout", 32'(bus.timeout), 32'h0);
        check("rst_state", 32'(state), 32'(IDLE));
        rst = 1'b0;
        tick();
        expect_grant("first", 2'd0);
        check("first_state", 32'(state), 32'(GRANT));

        // rotation with rel pulsed every grant
        bus.rel = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_grant($sformatf("rot%0d", i), rot_exp[i]);
        end
        bus.rel = 1'b0;
        tick();
        expect_grant("rot_hold", 2'd0);

        // sparse requests 1010
        do_reset();
        bus.req = 4'b1010;
        tick();
        expect_grant("sparse0", 2'd1);
        bus.rel = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            expect_grant($sformatf("sparse%0d", i + 1), sparse_exp[i]);
        end
        bus.rel = 1'b0;

        // owner drops with nothing else pending: idle, sel retained
        do_reset();
        bus.req = 4'b0100;
        tick();
        expect_grant("own2", 2'd2);
        bus.req = 4'b0000;
        tick();
        check("drop_idle_valid", 32'(bus.valid), 32'h0);
        check("drop_idle_gnt", 32'(bus.gnt), 32'h0);
        check("drop_idle_sel", 32'(bus.sel), 32'd2);
        check("drop_idle_state", 32'(state), 32'(IDLE));

        // rel while idle is ignored
        bus.rel = 1'b1;
        tick();
        check("idle_rel_valid", 32'(bus.valid), 32'h0);
        bus.rel = 1'b0;

        // pick from last=2 finds ch0, then ch2 regained and owner drop hands over
        bus.req = 4'b0101;
        tick();
        expect_grant("after_idle", 2'd0);
        bus.req = 4'b0100;
        tick();
        expect_grant("drop_to2", 2'd2);
        bus.req = 4'b0001;
        tick();
        expect_grant("drop_to0", 2'd0);

        // hold limit: req=0011, no rel
        do_reset();
        bus.req = 4'b0011;
        for (int i = 0; i < 4; i++) begin
            tick();
            check($sformatf("hold_gnt%0d", i), 32'(bus.gnt), 32'h1);
            check($sformatf("hold_to%0d", i), 32'(bus.timeout), 32'h0);
        end
        tick();
`ifdef MUX_SEL_ARB_TIMEOUT_EN
        check("to_gnt", 32'(bus.gnt), 32'h2);
        check("to_pulse", 32'(bus.timeout), 32'h1);
        tick();
        check("to_gnt_after", 32'(bus.gnt), 32'h2);
        check("to_pulse_end", 32'(bus.timeout), 32'h0);
`else
        check("noto_gnt", 32'(bus.gnt), 32'h1);
        check("noto_pulse", 32'(bus.timeout), 32'h0);
        tick();
        check("noto_gnt_after", 32'(bus.gnt), 32'h1);
        check("noto_pulse_after", 32'(bus.timeout), 32'h0);
`endif

        // asynchronous reset mid-grant
        do_reset();
        bus.req = 4'b0100;
        tick();
        expect_grant("pre_arst", 2'd2);
        #2;
        rst = 1'b1;
        #1;
        check("arst_gnt", 32'(bus.gnt), 32'h0);
        check("arst_valid", 32'(bus.valid), 32'h0);
        check("arst_sel", 32'(bus.sel), 32'h0);
        tick();
        rst = 1'b0;
        tick();
        expect_grant("post_arst", 2'd2);

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
